cache_fill_ctrl: RTL and testbench
==================================

Name: cache_fill_ctrl

Overview:
- Miss-handling responder for the direct-mapped cache. On a cache miss it fetches the whole 16-byte block (8 × 16-bit words) from the multi-cycle main memory.
- Each returned word is written into the cache data array, then the tag/valid entry is written.
- Sits between the cache and the memory model. Drives the cache's data-write, tag-write and word-number inputs, and the memory's read-request port.

Parameters:
- WORDS, 8, words per cache block; power of two.
- ADDR_W, 16, address width in bits.
- CNT_W, 3, log2(WORDS); width of the word counters.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- miss_detected  in  1  Miss from cache, qualified by read enable.
- miss_address  in  ADDR_W  address that missed; sampled on the accepting cycle.
- memory_data  in  16  read data from memory.
- memory_data_valid  in  1  memory_data is valid this cycle.
- fsm_busy  out  1  fill in progress; pipeline stall.
- mem_en  out  1  memory read request this cycle.
- memory_address  out  ADDR_W  memory read address.
- fill_address  out  ADDR_W  block-aligned address to drive the cache Address port during the fill.
- write_data_array  out  1  write one word into the cache data array.
- write_tag_array  out  1  write tag/valid for the block.
- word_num  out  CNT_W  word index for the cache write (Word_Num).
- data_to_cache  out  16  data for the cache Data_In port; equals memory_data.

Behaviour:
- Reset (rst=0, async): state=IDLE; issue_cnt=0, recv_cnt=0, base=0. All outputs 0: fsm_busy, mem_en, write_data_array, write_tag_array, word_num, memory_address, fill_address.
- Reset asserted mid-fill aborts the fill. No tag write occurs and the block stays invalid.
- States: IDLE, FILL.
- IDLE:
  - All outputs 0 and memory_data_valid is ignored.
  - If miss_detected=1: latch base={miss_address[ADDR_W-1:4],4'b0000}, clear both counters, and go to FILL next cycle.
- FILL:
  - fsm_busy=1.
  - fill_address=base.
  - data_to_cache=memory_data.
- FILL request path:
  - mem_en=1 while issue_cnt < WORDS, one request per cycle, back-to-back.
  - memory_address = base + (issue_cnt << 1).
  - issue_cnt increments each cycle mem_en=1 and saturates at WORDS; it needs CNT_W+1 bits internally.
  - When mem_en=0, memory_address holds base.
- FILL response path:
  - Each cycle memory_data_valid=1, drive write_data_array=1 and word_num=recv_cnt (combinational, same cycle), then increment recv_cnt.
  - Responses arrive in request order at any latency ≥1. Gaps between valids are legal.
- Completion:
  - On the cycle memory_data_valid=1 with recv_cnt==WORDS-1, also assert write_tag_array=1, in the same cycle as the last data write.
  - Next state is IDLE and fsm_busy drops the following cycle.
- miss_detected is ignored during FILL. The stalled pipeline re-presents the access after the fill and now hits.
- memory_data_valid while issue_cnt==0 cannot occur; implementation need not check for it.
- A miss can be accepted on the cycle immediately after returning to IDLE. Minimum fill length is WORDS+latency cycles.
- All state-changing logic uses one always block sensitive to posedge clk / negedge rst. Outputs are decoded combinationally from state, counters and memory_data_valid.

Decomposition:
- Shared package/include: state encodings (IDLE=1'b0, FILL=1'b1), WORDS, CNT_W, and the block-offset width (4 bits = byte offset within block).
- One natural sub-module, fill_counter: a CNT_W+1-bit enable/clear/saturating counter, instantiated twice (issue and receive).

Test Plan:
- Reset: hold rst=0 with random inputs, then release → all outputs 0 and state IDLE. Pulse miss_detected → fsm_busy=1 on the next cycle.
- Basic fill, latency 4: miss_address=16'h1236 →
  - mem_en high 8 consecutive cycles with memory_address 16'h1230,1232,…,123E.
  - write_data_array pulses with word_num 0..7 and data_to_cache matching the returned data.
  - write_tag_array only with word 7.
  - fsm_busy low the cycle after.
- Gapped responses: memory_data_valid toggled 1-0-1-0 → exactly 8 data writes, word_num increasing by 1 per valid, tag write with the 8th.
- Miss during fill: miss_detected=1 with miss_address=16'hABC0 mid-fill → ignored; all requests stay within base 16'h1230.
- Reset mid-fill: drop rst after 3 returned words → all outputs 0 immediately, no write_tag_array. A new miss at 16'h00F2 then fills block 16'h00F0 from word 0.
- Back-to-back: second miss presented the first IDLE cycle after a fill → accepted at once; new base latched correctly.

Source files
------------

// File: rtl/cache_fill_ctrl_pkg.sv
// Shared constants and state encoding for the cache miss fill controller.
package cache_fill_ctrl_pkg;

  localparam int BLK_WORDS  = 8;   // 16-bit words per cache block
  localparam int BLK_CNT_W  = 3;   // log2(BLK_WORDS)
  localparam int BLK_ADDR_W = 16;
  localparam int OFFSET_W   = 4;   // byte offset within a 16-byte block

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Cache/memory-side signals of the fill controller; master = controller, slave = cache+memory.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 3
);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic [15:0]       memory_data;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_en;
  logic [ADDR_W-1:0] memory_address;
  logic [ADDR_W-1:0] fill_address;
  logic              write_data_array;
  logic              write_tag_array;
  logic [CNT_W-1:0]  word_num;
  logic [15:0]       data_to_cache;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, mem_en, memory_address, fill_address,
           write_data_array, write_tag_array, word_num, data_to_cache
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, mem_en, memory_address, fill_address,
           write_data_array, write_tag_array, word_num, data_to_cache
  );

endinterface

// File: rtl/cache_fill_ctrl_fill_counter.sv
// Word counter with synchronous clear and enable; stops at WORDS.
// One extra bit so that "all WORDS issued" is representable.
module cache_fill_ctrl_fill_counter #(
  parameter int WORDS = 8,
  parameter int CNT_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [CNT_W:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != (CNT_W+1)'(WORDS))) begin
      count <= count + (CNT_W+1)'(1);
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss fill controller: requests a whole block back-to-back, writes each returned
// word into the data array and writes the tag together with the last word.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int WORDS  = BLK_WORDS,
  parameter int ADDR_W = BLK_ADDR_W,
  parameter int CNT_W  = BLK_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_ctrl_if.master fif
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W:0]    issue_cnt;
  logic [CNT_W:0]    recv_cnt;
  logic              accept;
  logic              issue_en;
  logic              recv_en;
  logic              last_word;
  logic              unused_offset;

  assign accept    = (state == IDLE) && fif.miss_detected;
  assign issue_en  = (state == FILL) && (issue_cnt < (CNT_W+1)'(WORDS));
  assign recv_en   = (state == FILL) && fif.memory_data_valid;
  assign last_word = (recv_cnt == (CNT_W+1)'(WORDS-1));

  // The byte offset only selects the word the pipeline wanted; the fill is block-wide.
  assign unused_offset = ^fif.miss_address[OFFSET_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base <= {fif.miss_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      end
    end
  end

  cache_fill_ctrl_fill_counter #(.WORDS(WORDS), .CNT_W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (issue_en),
    .count (issue_cnt)
  );

  cache_fill_ctrl_fill_counter #(.WORDS(WORDS), .CNT_W(CNT_W)) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (recv_en),
    .count (recv_cnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fif.miss_detected) state_nxt = FILL;
      FILL:    if (fif.memory_data_valid && last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fif.fsm_busy         = 1'b0;
    fif.mem_en           = 1'b0;
    fif.memory_address   = '0;
    fif.fill_address     = '0;
    fif.write_data_array = 1'b0;
    fif.write_tag_array  = 1'b0;
    fif.word_num         = '0;
    fif.data_to_cache    = fif.memory_data;
    if (state == FILL) begin
      fif.fsm_busy         = 1'b1;
      fif.fill_address     = base;
      fif.mem_en           = issue_en;
      fif.memory_address   = issue_en ? base + (ADDR_W'(issue_cnt) << 1) : base;
      fif.write_data_array = fif.memory_data_valid;
      fif.word_num         = recv_cnt[CNT_W-1:0];
      fif.write_tag_array  = fif.memory_data_valid && last_word;
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized scoreboard bench for cache_fill_ctrl with a latency/gap memory model.
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_W(16), .CNT_W(3)) fif ();

  cache_fill_ctrl #(.WORDS(8), .ADDR_W(16), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  typedef struct { logic [15:0] a; int c; } req_t;
  typedef struct { logic [2:0] w; logic [15:0] d; logic t; } wr_t;

  logic [15:0] exp_req[$];
  wr_t         exp_wr[$];
  req_t        pend[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 4;
  int gap_mode = 0;
  int n_writes = 0;
  bit resp_en  = 1'b0;
  bit busy_chk = 1'b0;
  bit gap_tog  = 1'b1;
  logic [15:0] cur_base = '0;
  logic [15:0] salt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a miss at any address fills its 16-byte block, word 0 first, tag with word 7.
  task automatic expect_fill(input logic [15:0] addr);
    logic [15:0] b;
    b = addr & 16'hFFF0;
    cur_base = b;
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back(b + 16'(2 * i));
      exp_wr.push_back('{w: 3'(i), d: mem_word(b + 16'(2 * i)), t: (i == 7)});
    end
  endtask

  // Monitor: compares every observed request and cache write against the scoreboard.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (busy_chk) begin
      chk("busy_drop_after_tag", fif.fsm_busy, 0);
      busy_chk = 1'b0;
    end
    if (!fif.fsm_busy)
      chk("idle_outputs_zero", {fif.mem_en, fif.write_data_array, fif.write_tag_array,
                                fif.word_num, fif.memory_address, fif.fill_address}, 0);
    else
      chk("fill_address", fif.fill_address, cur_base);
    if (fif.mem_en) begin
      chk("req_expected", exp_req.size() > 0, 1);
      if (exp_req.size() > 0) chk("memory_address", fif.memory_address, exp_req.pop_front());
      pend.push_back('{a: fif.memory_address, c: cyc});
    end
    if (fif.write_tag_array) begin
      chk("tag_with_data", fif.write_data_array, 1);
      busy_chk = 1'b1;
    end
    if (fif.write_data_array) begin
      n_writes++;
      chk("write_expected", exp_wr.size() > 0, 1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        chk("word_num", fif.word_num, e.w);
        chk("data_to_cache", fif.data_to_cache, e.d);
        chk("tag_write", fif.write_tag_array, e.t);
      end
    end
  end

  // Memory model: answers requests in order after lat cycles, optionally with gaps.
  initial forever begin
    bit go;
    @(posedge clk);
    #1;
    if (resp_en) begin
      fif.memory_data_valid = 1'b0;
      fif.memory_data       = 16'($urandom);
      if (pend.size() > 0 && cyc >= pend[0].c + lat) begin
        case (gap_mode)
          0:       go = 1'b1;
          1:       go = gap_tog;
          default: go = 1'($urandom_range(0, 1));
        endcase
        gap_tog = !gap_tog;
        if (go) begin
          fif.memory_data_valid = 1'b1;
          fif.memory_data       = mem_word(pend[0].a);
          void'(pend.pop_front());
        end
      end
    end
  end

  task automatic do_miss(input logic [15:0] addr);
    chk("idle_before_miss", fif.fsm_busy, 0);
    fif.miss_detected = 1'b1;
    fif.miss_address  = addr;
    expect_fill(addr);
    @(posedge clk);
    #1;
    fif.miss_detected = 1'b0;
    fif.miss_address  = 16'($urandom);
    @(negedge clk);
    chk("busy_after_miss", fif.fsm_busy, 1);
  endtask

  task automatic wait_done(input bit noise);
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (exp_wr.size() == 0 && exp_req.size() == 0) break;
      if (noise) begin
        fif.miss_detected = ($urandom_range(0, 3) == 0);
        fif.miss_address  = 16'($urandom);
      end
    end
    fif.miss_detected = 1'b0;
    chk("fill_completes_in_time", k < 400, 1);
  endtask

  initial begin
    int w0;
    int k;
    salt = 16'($urandom);
    rst  = 1'b0;
    fif.miss_detected     = 1'b0;
    fif.miss_address      = '0;
    fif.memory_data       = '0;
    fif.memory_data_valid = 1'b0;

    // Reset held with random inputs, then idle with random memory noise.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      fif.miss_detected     = 1'($urandom);
      fif.miss_address      = 16'($urandom);
      fif.memory_data_valid = 1'($urandom);
      fif.memory_data       = 16'($urandom);
      #1 chk("reset_busy", fif.fsm_busy, 0);
    end
    fif.miss_detected = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      fif.memory_data_valid = 1'($urandom);
      fif.memory_data       = 16'($urandom);
    end
    resp_en = 1'b1;
    @(posedge clk);
    #1;

    // Basic fill with latency 4, then a back-to-back miss.
    lat = 4; gap_mode = 0;
    do_miss(16'h1236);
    chk("mem_en_burst", fif.mem_en, 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("mem_en_burst", fif.mem_en, 1);
    end
    @(negedge clk);
    chk("mem_en_stops", fif.mem_en, 0);
    wait_done(1'b0);
    do_miss(16'h7F1A);
    wait_done(1'b0);

    // Alternating valid/gap responses.
    gap_mode = 1; gap_tog = 1'b1; lat = 2;
    do_miss(16'h2468);
    wait_done(1'b0);

    // Miss presented mid-fill must be ignored.
    gap_mode = 0; lat = 3;
    do_miss(16'h1236);
    repeat (3) begin @(posedge clk); #1; end
    fif.miss_detected = 1'b1;
    fif.miss_address  = 16'hABC0;
    repeat (3) begin @(posedge clk); #1; end
    fif.miss_detected = 1'b0;
    wait_done(1'b0);
    repeat (3) @(negedge clk);
    chk("no_extra_fill", fif.fsm_busy, 0);

    // Reset after three returned words aborts the fill.
    @(posedge clk);
    #1;
    lat = 4;
    w0 = n_writes;
    do_miss(16'h4562);
    for (k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (n_writes >= w0 + 3) break;
    end
    chk("three_words_returned", n_writes - w0, 3);
    rst = 1'b0;
    resp_en = 1'b0;
    fif.memory_data_valid = 1'b0;
    pend.delete(); exp_req.delete(); exp_wr.delete();
    busy_chk = 1'b0;
    #1 chk("reset_midfill_outputs", {fif.fsm_busy, fif.mem_en, fif.write_data_array,
                                      fif.write_tag_array, fif.word_num,
                                      fif.memory_address, fif.fill_address}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    resp_en = 1'b1;
    @(posedge clk);
    #1;
    do_miss(16'h00F2);
    wait_done(1'b0);

    // Randomized fills: latency, gaps, idle spacing and ignored misses.
    for (int n = 0; n < 25; n++) begin
      lat      = $urandom_range(1, 6);
      gap_mode = $urandom_range(0, 2);
      gap_tog  = 1'b1;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      do_miss(16'($urandom));
      wait_done(1'($urandom));
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_req.size() + exp_wr.size() + pend.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
